// File: rtl/dac7611_arbiter_ctrl_if.sv
// Requester handshake, status flags and DAC7611 pin bundle for dac7611_arbiter_ctrl.
// The slave modport is the controller side; master is the requester/board side.
interface dac7611_arbiter_ctrl_if;
   logic        enable;
   logic        req0;
   logic        req1;
   logic [11:0] data0;
   logic [11:0] data1;
   logic        ack0;
   logic        ack1;
   logic        busy;
   logic        done;
   logic        CLK_3;
   logic        SDI_4;
   logic        LD_5;

   modport slave (
      input  enable, req0, req1, data0, data1,
      output ack0, ack1, busy, done, CLK_3, SDI_4, LD_5
   );

   modport master (
      output enable, req0, req1, data0, data1,
      input  ack0, ack1, busy, done, CLK_3, SDI_4, LD_5
   );
endinterface

// File: rtl/dac7611_arbiter_ctrl.sv
// Two-requester round-robin front end for a DAC7611 12-bit serial DAC: grants one
// requester, shifts its code MSB first at clk_X4/4, then pulses LD_5 low to load it.
module dac7611_arbiter_ctrl #(
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic                         clk_X4,
   input  logic                         rst_n,
   dac7611_arbiter_ctrl_if.slave        bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2,
      LOAD  = 2'd3
   } state_e;

   localparam logic [3:0] LAST_HOLD = 4'd1;
   localparam logic [3:0] LAST_GAP  = 4'(GAP_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]  phase_q, phase_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [11:0] shreg_q, shreg_d;
   logic        last_grant_q, last_grant_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        clk3_q, clk3_d;
   logic        sdi_q, sdi_d;
   logic        ld_q, ld_d;

   logic        grant_any;
   logic        grant_sel;

   // grant_sel: 0 selects requester 0, 1 selects requester 1
   always_comb begin
      grant_any = bus.enable && (bus.req0 || bus.req1);
      if (bus.req0 && bus.req1) begin
         grant_sel = ~last_grant_q;
      end else begin
         grant_sel = bus.req1;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      phase_d      = phase_q;
      wait_cnt_d   = wait_cnt_q;
      shreg_d      = shreg_q;
      last_grant_d = last_grant_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      done_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (grant_any) begin
               state_d      = SHIFT;
               bit_cnt_d    = 4'd11;
               phase_d      = 2'd0;
               shreg_d      = grant_sel ? bus.data1 : bus.data0;
               last_grant_d = grant_sel;
               ack0_d       = ~grant_sel;
               ack1_d       = grant_sel;
            end
         end

         SHIFT: begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
               if (bit_cnt_q == 4'd0) begin
                  state_d    = HOLD;
                  wait_cnt_d = 4'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q - 4'd1;
                  shreg_d   = {shreg_q[10:0], shreg_q[11]};
               end
            end
         end

         HOLD: begin
            wait_cnt_d = wait_cnt_q + 4'd1;
            if (wait_cnt_q == LAST_HOLD) begin
               state_d    = LOAD;
               wait_cnt_d = 4'd0;
               done_d     = 1'b1;
            end
         end

         LOAD: begin
            wait_cnt_d = wait_cnt_q + 4'd1;
            if (wait_cnt_q == LAST_GAP) begin
               state_d    = IDLE;
               wait_cnt_d = 4'd0;
            end
         end

         default: state_d = IDLE;
      endcase

      // Pins are decoded from the next state so they leave the block straight from flops.
      busy_d = (state_d != IDLE);
      ld_d   = (state_d == SHIFT) || (state_d == HOLD);
      clk3_d = 1'b1;
      sdi_d  = 1'b0;
      if (state_d == SHIFT) begin
         clk3_d = phase_d[1];
         sdi_d  = shreg_d[11];
      end
   end

   always_ff @(posedge clk_X4 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         bit_cnt_q    <= 4'd0;
         phase_q      <= 2'd0;
         wait_cnt_q   <= 4'd0;
         shreg_q      <= 12'd0;
         last_grant_q <= 1'b1;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         clk3_q       <= 1'b1;
         sdi_q        <= 1'b0;
         ld_q         <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge values computed above.
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         phase_q      <= phase_d;
         wait_cnt_q   <= wait_cnt_d;
         shreg_q      <= shreg_d;
         last_grant_q <= last_grant_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         clk3_q       <= clk3_d;
         sdi_q        <= sdi_d;
         ld_q         <= ld_d;
      end
   end

   assign bus.ack0  = ack0_q;
   assign bus.ack1  = ack1_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.CLK_3 = clk3_q;
   assign bus.SDI_4 = sdi_q;
   assign bus.LD_5  = ld_q;

endmodule

// File: tb/tb_dac7611_arbiter_ctrl.sv
// Directed bench for dac7611_arbiter_ctrl: frames are reconstructed from the pins
// each falling clk edge and compared against hand-computed values.
module tb_dac7611_arbiter_ctrl;

   localparam int GAP = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   dac7611_arbiter_ctrl_if bus();

   dac7611_arbiter_ctrl #(.GAP_CYCLES(GAP)) dut (
      .clk_X4 (clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int          n_smp, n_rise, n_ack0, n_ack1, n_done, n_busy;
   int          n_ld_hi, n_ld_lo_busy, n_sdi_hi, done_at;
   logic        prev_clk;
   logic [11:0] cur_word;
   int          cur_bits;
   logic [11:0] words[$];
   int          ack_at[$];
   int          ack_who[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] pins();
      return {bus.CLK_3, bus.SDI_4, bus.LD_5, bus.busy, bus.done, bus.ack0, bus.ack1};
   endfunction

   function automatic logic [31:0] word_at(input int k);
      if (k < words.size()) return 32'(words[k]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] ack_at_k(input int k);
      if (k < ack_at.size()) return 32'(ack_at[k]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] ack_who_k(input int k);
      if (k < ack_who.size()) return 32'(ack_who[k]);
      return 32'hFFFF_FFFF;
   endfunction

   task automatic clear_stats();
      n_smp = 0; n_rise = 0; n_ack0 = 0; n_ack1 = 0; n_done = 0; n_busy = 0;
      n_ld_hi = 0; n_ld_lo_busy = 0; n_sdi_hi = 0; done_at = -1;
      prev_clk = bus.CLK_3;
      cur_word = 12'd0;
      cur_bits = 0;
      words.delete();
      ack_at.delete();
      ack_who.delete();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         n_smp++;
         if (bus.CLK_3 && !prev_clk) begin
            n_rise++;
            cur_word = {cur_word[10:0], bus.SDI_4};
            cur_bits++;
            if (cur_bits == 12) begin
               words.push_back(cur_word);
               cur_bits = 0;
            end
         end
         prev_clk = bus.CLK_3;
         if (bus.ack0) begin n_ack0++; ack_at.push_back(n_smp); ack_who.push_back(0); end
         if (bus.ack1) begin n_ack1++; ack_at.push_back(n_smp); ack_who.push_back(1); end
         if (bus.done) begin n_done++; done_at = n_smp; end
         if (bus.busy) n_busy++;
         if (bus.LD_5) n_ld_hi++;
         if (bus.busy && !bus.LD_5) n_ld_lo_busy++;
         if (bus.SDI_4) n_sdi_hi++;
      end
   endtask

   // Single-requester frame on port 0: request for one cycle, then idle long enough to finish.
   task automatic frame0(input logic [11:0] code);
      clear_stats();
      bus.data0 = code;
      bus.req0  = 1'b1;
      run(1);
      bus.req0  = 1'b0;
      run(60);
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.req0   = 1'b0;
      bus.req1   = 1'b0;
      bus.data0  = 12'd0;
      bus.data1  = 12'd0;

      // Reset state, reached asynchronously before any clock edge
      #1 rst_n = 1'b0;
      #1 chk("reset_pins", 32'(pins()), 32'h40);
      run(2);
      rst_n = 1'b1;
      bus.enable = 1'b1;

      // Single frame with 0xAAA
      frame0(12'hAAA);
      chk("aaa_ack0",     n_ack0, 1);
      chk("aaa_ack1",     n_ack1, 0);
      chk("aaa_ack_at",   ack_at_k(0), 1);
      chk("aaa_word",     word_at(0), 12'hAAA);
      chk("aaa_nwords",   words.size(), 1);
      chk("aaa_rises",    n_rise, 12);
      chk("aaa_ld_hi",    n_ld_hi, 50);
      chk("aaa_ld_lo",    n_ld_lo_busy, GAP);
      chk("aaa_done",     n_done, 1);
      chk("aaa_done_at",  done_at, 51);
      chk("aaa_busy",     n_busy, 54);
      chk("aaa_sdi_hi",   n_sdi_hi, 24);
      chk("aaa_idle",     32'(pins()), 32'h40);

      // Fresh reset so last-grant is back to 1, then continuous contention
      @(negedge clk);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      clear_stats();
      bus.data0 = 12'h123;
      bus.data1 = 12'h456;
      bus.req0  = 1'b1;
      bus.req1  = 1'b1;
      run(151);
      bus.req0  = 1'b0;
      bus.req1  = 1'b0;
      run(20);
      chk("rr_nacks",  n_ack0 + n_ack1, 3);
      chk("rr_who0",   ack_who_k(0), 0);
      chk("rr_who1",   ack_who_k(1), 1);
      chk("rr_who2",   ack_who_k(2), 0);
      chk("rr_at0",    ack_at_k(0), 1);
      chk("rr_at1",    ack_at_k(1), 56);
      chk("rr_at2",    ack_at_k(2), 111);
      chk("rr_word0",  word_at(0), 12'h123);
      chk("rr_word1",  word_at(1), 12'h456);
      chk("rr_word2",  word_at(2), 12'h123);
      chk("rr_done",   n_done, 3);

      // req1 arrives while frame 0 is in flight; data0 changes mid-frame
      clear_stats();
      bus.data0 = 12'h5A3;
      bus.req0  = 1'b1;
      run(1);
      bus.req0  = 1'b0;
      bus.data1 = 12'h3C6;
      bus.req1  = 1'b1;
      run(10);
      bus.data0 = 12'hFFF;
      run(60);
      bus.req1  = 1'b0;
      run(50);
      chk("late_word0", word_at(0), 12'h5A3);
      chk("late_word1", word_at(1), 12'h3C6);
      chk("late_who1",  ack_who_k(1), 1);
      chk("late_at1",   ack_at_k(1), 56);
      chk("late_done",  n_done, 2);

      // enable low blocks grants entirely
      clear_stats();
      bus.enable = 1'b0;
      bus.data0  = 12'h111;
      bus.req0   = 1'b1;
      run(10);
      chk("dis_ack",  n_ack0 + n_ack1, 0);
      chk("dis_busy", n_busy, 0);
      chk("dis_pins", 32'(pins()), 32'h40);

      // enable drops at SHIFT bit 5: frame completes, no regrant
      clear_stats();
      bus.enable = 1'b1;
      run(1);
      run(24);
      bus.enable = 1'b0;
      run(60);
      chk("endrop_ack",  n_ack0, 1);
      chk("endrop_word", word_at(0), 12'h111);
      chk("endrop_done", n_done, 1);
      chk("endrop_busy", n_busy, 54);
      chk("endrop_idle", 32'(pins()), 32'h40);
      bus.req0   = 1'b0;
      bus.enable = 1'b1;

      // Reset at SHIFT bit 6 discards the frame immediately
      clear_stats();
      bus.data0 = 12'h9C5;
      bus.req0  = 1'b1;
      run(1);
      bus.req0  = 1'b0;
      run(20);
      rst_n = 1'b0;
      #1 chk("rst_mid_pins", 32'(pins()), 32'h40);
      bus.req0 = 1'b1;
      run(3);
      chk("rst_mid_done",  n_done, 0);
      chk("rst_mid_ldlo",  n_ld_lo_busy, 0);
      chk("rst_mid_acks",  n_ack0, 1);
      rst_n = 1'b1;
      clear_stats();
      run(1);
      bus.req0 = 1'b0;
      run(60);
      chk("post_rst_at",   ack_at_k(0), 1);
      chk("post_rst_word", word_at(0), 12'h9C5);
      chk("post_rst_done", done_at, 51);

      // All-ones and all-zeros codes
      frame0(12'hFFF);
      chk("fff_word",  word_at(0), 12'hFFF);
      chk("fff_rises", n_rise, 12);
      chk("fff_sdi",   n_sdi_hi, 48);
      frame0(12'h000);
      chk("zero_word",  word_at(0), 12'h000);
      chk("zero_rises", n_rise, 12);
      chk("zero_sdi",   n_sdi_hi, 0);
      chk("zero_done",  n_done, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dac7611_arbiter_ctrl.md
DAC7611_ARBITER_CTRL -- requirements
Module: dac7611_arbiter_ctrl

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 4: number of clk_X4 cycles LD_5 is held low after each frame, legal range 2..15.
REQ-002 The block SHALL have port clk_X4, input, 1 bit: single clock, 4x the DAC serial clock rate; all flops SHALL use its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: high permits new grants.
REQ-005 The block SHALL have ports req0 and req1, input, 1 bit each: requester 0 and requester 1 frame requests.
REQ-006 The block SHALL have ports data0 and data1, input, 12 bits each: DAC codes, valid while the matching req is high.
REQ-007 The block SHALL have ports ack0 and ack1, output, 1 bit each: one-cycle pulse meaning the code was captured.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever a frame is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when the DAC load begins.
REQ-010 The block SHALL have ports CLK_3, SDI_4 and LD_5, output, 1 bit each: DAC7611 pins 3 (CLK), 4 (SDI) and 5 (LD).

Function
REQ-011 The block SHALL implement FSM states IDLE, SHIFT, HOLD and LOAD.
REQ-012 All outputs SHALL be registered or decoded only from state registers (Moore); no output SHALL depend combinationally on req, data or enable.
REQ-013 In IDLE, outputs SHALL be CLK_3=1, SDI_4=0, LD_5=0, busy=0.
REQ-014 IDLE SHALL transition to SHIFT at a rising edge where enable=1 and (req0|req1)=1.
REQ-015 At that edge the block SHALL capture the winner's data into a 12-bit shift register and assert the winner's ack for exactly the next cycle, which is the first SHIFT cycle.
REQ-016 Arbitration SHALL be round-robin: with both requests high, the requester not granted last SHALL win; a single request SHALL always win; the last-grant register SHALL reset to 1, so req0 wins the first tie.
REQ-017 SHIFT SHALL last exactly 48 cycles: 12 bits, MSB first, 4 cycles per bit, indexed by a 4-bit bit counter (11 down to 0) and a 2-bit phase counter.
REQ-018 In SHIFT, bit phases 0-1 SHALL drive CLK_3=0 and phases 2-3 SHALL drive CLK_3=1, giving one rising CLK_3 edge mid-bit with SDI_4 stable across it.
REQ-019 In SHIFT, SDI_4 SHALL equal the current bit for all 4 phases, and LD_5=1.
REQ-020 After phase 3 of bit 0, the FSM SHALL enter HOLD.
REQ-021 HOLD SHALL last 2 cycles with CLK_3=1, SDI_4=0, LD_5=1.
REQ-022 LOAD SHALL last GAP_CYCLES cycles with CLK_3=1, SDI_4=0, LD_5=0.
REQ-023 done SHALL be high only in the first LOAD cycle.
REQ-024 The FSM SHALL return to IDLE after the last LOAD cycle.
REQ-025 busy SHALL be 1 in SHIFT, HOLD and LOAD.
REQ-026 Requests SHALL be ignored while busy; req and data changes during a frame SHALL NOT affect the frame in flight.
REQ-027 enable falling mid-frame SHALL NOT abort the frame; only the next grant is blocked.
REQ-028 A requester holding req high through ack SHALL be granted again, subject to arbitration; the earliest regrant is the IDLE cycle after LOAD, giving a frame period of 1+48+2+GAP_CYCLES cycles.
REQ-029 A data code of 12'h000 or 12'hFFF SHALL be transmitted without special casing.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, CLK_3=1, SDI_4=0, LD_5=0, ack0=ack1=0, busy=0, done=0, counters=0, shift register=0 and last-grant=1.
REQ-031 Reset asserted mid-frame SHALL discard the frame with no LD_5 low pulse and no done.
REQ-032 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge on which rst_n=1.

Verification
REQ-033 The bench SHALL cover: req0=1, data0=12'hAAA, enable=1 -> ack0 pulses once; SDI_4 per bit = 1,0,1,0,...,0; 12 CLK_3 rising edges; LD_5 high 50 cycles then low GAP_CYCLES=4 cycles; done once; busy high 54 cycles.
REQ-034 The bench SHALL cover: req0=req1=1 held continuously with data0=12'h123, data1=12'h456 -> frames alternate 123, 456, 123; acks alternate starting with ack0; frame period 55 cycles.
REQ-035 The bench SHALL cover: req1 asserted during a req0 frame, with data0 changed mid-frame -> frame 0 shifts its original captured code; req1 is granted on the IDLE cycle after LOAD.
REQ-036 The bench SHALL cover: enable=0 with req0=1 -> no ack, busy=0, outputs at idle values; enable dropped at SHIFT bit 5 -> frame completes, no new grant.
REQ-037 The bench SHALL cover: rst_n pulsed low at SHIFT bit 6 -> outputs reach idle values before the next clock edge; no done; a new req0 after reset is served normally.
REQ-038 The bench SHALL cover: data=12'hFFF, then 12'h000 -> SDI_4 constant 1, then constant 0, during SHIFT; CLK_3 edge count is 12 for each frame.
